alu_issue_arbiter: RTL
======================

# alu_issue_arbiter

Two-port arbiter that shares the single registered ALU between two requesters, the issue slots of the dual-issue execute stage. Requests are accepted with a valid/ready handshake under round-robin priority. Each accepted request drives the ALU operand and opcode inputs and is tracked while in flight. The ALU result is routed into a one-entry response buffer owned by the issuing requester.

## Interface
- TAG_W, 4, width of the requester-supplied tag returned with each result
- clk  in  1  clock; the ALU is clocked by the same clock
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request valid, N = 0, 1
- reqN_ready  out  1  request accepted this cycle when reqN_valid && reqN_ready
- reqN_op  in  4  ALU opcode 0x0..0x7; bit 3 set is illegal
- reqN_a, reqN_b  in  32  operands
- reqN_tag  in  TAG_W  opaque tag
- alu_op  out  4  to ALU aluop
- alu_in1, alu_in2  out  32  to ALU aluin1, aluin2
- alu_out, alu_slt  in  32  from ALU aluout, slt (registered, valid one cycle after issue)
- rspN_valid  out  1  response buffer N full
- rspN_ready  in  1  consumer takes the response when rspN_valid && rspN_ready
- rspN_result, rspN_slt  out  32  captured alu_out / alu_slt, or 0 on error
- rspN_tag  out  TAG_W  tag of the completed request
- rspN_err  out  1  request carried an illegal opcode

## Operation
- Eligibility of requester N in a cycle: NOT (infl_valid && infl_owner == N) AND (!rspN_valid || rspN_ready).
- reqN_ready = eligible(N) AND (N wins arbitration). It is combinational and may depend on reqN_valid of both ports.
- Arbitration:
  - If only one requester is valid and eligible, it wins.
  - If both are, the requester pointed to by rr_ptr wins.
  - On every accepted grant, rr_ptr becomes the loser's index. If nothing is granted, rr_ptr holds.
- Issue, in the cycle a request is accepted:
  - A legal op drives alu_op = op, alu_in1 = a, alu_in2 = b combinationally.
  - An illegal op (op[3] = 1) drives alu_op = 4'h0 and both operands to 0. The ALU holds stale data for opcodes 8–15.
  - With no grant, the ALU inputs are driven with 4'h0 and zeros.
- In-flight register, loaded on the accepting edge: infl_valid = 1, infl_owner, infl_tag, infl_err = op[3].
- Completion, at the next edge:
  - If infl_valid, load rsp[infl_owner] with alu_out, alu_slt, infl_tag and infl_err. Set rsp valid.
  - If infl_err, force result and slt to 0.
  - Clear infl_valid unless a new grant occurs on the same edge.
- Response drain: on an edge with rspN_valid && rspN_ready, clear rspN_valid, unless the same edge loads a new completion for N, in which case the new entry overwrites.
- The eligibility rule guarantees a completion never lands in a full, non-draining buffer. There is no overflow path.
- Ordering: responses per requester are in issue order. The two ports are independent.

## Timing
- Reset values: rr_ptr = 0, infl_valid = 0, rsp0_valid = rsp1_valid = 0, all rsp data/tag/err = 0. Outputs alu_op = 0, alu_in1 = alu_in2 = 0, req0_ready = req1_ready = 0 while rst_n is low.
- Latency: accepted at edge E0, ALU registers at E0, response buffer loads at E1, rspN_valid is high in the cycle after E1. That is 2 cycles from accept to response.
- ALU utilisation: one issue per cycle when both ports alternate. A single port is limited to one issue every 2 cycles, because its own in-flight entry blocks it.
- Simultaneous events:
  - Grant, completion and drain on the same edge are all legal and all take effect.
  - The completing owner is never the newly granted requester.
- Reset asserted mid-operation: the in-flight op and buffered responses are discarded immediately (asynchronous). No response is produced for them after reset releases.
- Requesters must hold valid, op, operands and tag stable until accepted. The arbiter does not register request inputs.

## Test plan
- Single op: req0 op = 0x0, a = 5, b = 7, tag = 3, rsp0_ready = 1. Expect req0_ready at cycle 0, rsp0_valid at cycle 2, result 12, tag 3, err 0.
- Round-robin: both ports valid every cycle with op 0x1 (SUB), a = 10, b = 3. Grants alternate 0,1,0,1 starting with port 0 after reset. Every response has result 7 and slt 0.
- Backpressure: rsp1_ready = 0 with req1 held valid. After the first response buffers, req1_ready stays 0. Raise rsp1_ready: the buffer drains, req1 is re-granted in the same cycle, and the next response appears 2 cycles later.
- Illegal op: req0 op = 0x9, a = b = 0xFFFF_FFFF. Expect rsp0_err = 1, result 0, slt 0, tag echoed, alu_op = 0 during issue.
- SLT path: op = 0x1, a = 0xFFFF_FFFE (-2), b = 1. Expect result 0xFFFF_FFFD and slt = 1, delivered with the correct tag.
- Reset mid-flight: assert rst_n low the cycle after an accept. Expect rspN_valid = 0 throughout and after release, rr_ptr = 0, and the next grant goes to port 0 when both ports are valid.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// Shares one registered ALU between two issue slots: round-robin valid/ready
// arbitration, a single in-flight tracker and a one-entry response buffer per slot.
module alu_issue_arbiter #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [3:0]       req0_op_i,
   input  logic [31:0]      req0_a_i,
   input  logic [31:0]      req0_b_i,
   input  logic [TAG_W-1:0] req0_tag_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [3:0]       req1_op_i,
   input  logic [31:0]      req1_a_i,
   input  logic [31:0]      req1_b_i,
   input  logic [TAG_W-1:0] req1_tag_i,
   output logic [3:0]       alu_op_o,
   output logic [31:0]      alu_in1_o,
   output logic [31:0]      alu_in2_o,
   input  logic [31:0]      alu_out_i,
   input  logic [31:0]      alu_slt_i,
   output logic             rsp0_valid_o,
   input  logic             rsp0_ready_i,
   output logic [31:0]      rsp0_result_o,
   output logic [31:0]      rsp0_slt_o,
   output logic [TAG_W-1:0] rsp0_tag_o,
   output logic             rsp0_err_o,
   output logic             rsp1_valid_o,
   input  logic             rsp1_ready_i,
   output logic [31:0]      rsp1_result_o,
   output logic [31:0]      rsp1_slt_o,
   output logic [TAG_W-1:0] rsp1_tag_o,
   output logic             rsp1_err_o
);

   logic [1:0]            req_valid_s;
   logic [1:0]            rsp_ready_s;
   logic [1:0]            owner_hit_s;
   logic [1:0]            elig_s;
   logic [1:0]            cand_s;
   logic                  grant_s;
   logic                  win_s;
   logic [3:0]            sel_op_s;
   logic [31:0]           sel_a_s;
   logic [31:0]           sel_b_s;
   logic [TAG_W-1:0]      sel_tag_s;

   logic                  rr_ptr_q, rr_ptr_d;
   logic                  infl_valid_q, infl_valid_d;
   logic                  infl_owner_q, infl_owner_d;
   logic [TAG_W-1:0]      infl_tag_q, infl_tag_d;
   logic                  infl_err_q, infl_err_d;
   logic [1:0]            rsp_valid_q, rsp_valid_d;
   logic [1:0][31:0]      rsp_result_q, rsp_result_d;
   logic [1:0][31:0]      rsp_slt_q, rsp_slt_d;
   logic [1:0][TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic [1:0]            rsp_err_q, rsp_err_d;

   assign req_valid_s = {req1_valid_i, req0_valid_i};
   assign rsp_ready_s = {rsp1_ready_i, rsp0_ready_i};

   // owner_hit_s flags the port whose op sits in the ALU: it blocks that port and steers its completion
   assign owner_hit_s = {infl_valid_q & infl_owner_q, infl_valid_q & ~infl_owner_q};
   assign elig_s      = {2{rst_n}} & ~owner_hit_s & (~rsp_valid_q | rsp_ready_s);
   assign cand_s      = req_valid_s & elig_s;

   // Round-robin pick among eligible, valid requesters
   always_comb begin
      grant_s = 1'b0;
      win_s   = 1'b0;
      case (cand_s)
         2'b01:   begin grant_s = 1'b1; win_s = 1'b0;     end
         2'b10:   begin grant_s = 1'b1; win_s = 1'b1;     end
         2'b11:   begin grant_s = 1'b1; win_s = rr_ptr_q; end
         default: begin grant_s = 1'b0; win_s = 1'b0;     end
      endcase
   end

   assign req0_ready_o = grant_s & ~win_s;
   assign req1_ready_o = grant_s & win_s;

   // Winner's request fields
   always_comb begin
      sel_op_s  = req0_op_i;
      sel_a_s   = req0_a_i;
      sel_b_s   = req0_b_i;
      sel_tag_s = req0_tag_i;
      if (win_s) begin
         sel_op_s  = req1_op_i;
         sel_a_s   = req1_a_i;
         sel_b_s   = req1_b_i;
         sel_tag_s = req1_tag_i;
      end else begin
         sel_op_s  = req0_op_i;
         sel_a_s   = req0_a_i;
         sel_b_s   = req0_b_i;
         sel_tag_s = req0_tag_i;
      end
   end

   // ALU drive: illegal opcodes issue as op 0 on zero operands so the ALU never holds stale data
   always_comb begin
      alu_op_o  = 4'h0;
      alu_in1_o = 32'h0;
      alu_in2_o = 32'h0;
      if (grant_s && !sel_op_s[3]) begin
         alu_op_o  = sel_op_s;
         alu_in1_o = sel_a_s;
         alu_in2_o = sel_b_s;
      end else begin
         alu_op_o  = 4'h0;
         alu_in1_o = 32'h0;
         alu_in2_o = 32'h0;
      end
   end

   // Arbitration pointer and in-flight tracker next state
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      infl_valid_d = grant_s;
      infl_owner_d = infl_owner_q;
      infl_tag_d   = infl_tag_q;
      infl_err_d   = infl_err_q;
      if (grant_s) begin
         rr_ptr_d     = ~win_s;
         infl_owner_d = win_s;
         infl_tag_d   = sel_tag_s;
         infl_err_d   = sel_op_s[3];
      end else begin
         rr_ptr_d     = rr_ptr_q;
         infl_owner_d = infl_owner_q;
         infl_tag_d   = infl_tag_q;
         infl_err_d   = infl_err_q;
      end
   end

   // Response buffers: completion load takes precedence over drain
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_slt_d    = rsp_slt_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_err_d    = rsp_err_q;
      for (int n = 0; n < 2; n++) begin
         if (owner_hit_s[n]) begin
            rsp_valid_d[n]  = 1'b1;
            rsp_result_d[n] = infl_err_q ? 32'h0 : alu_out_i;
            rsp_slt_d[n]    = infl_err_q ? 32'h0 : alu_slt_i;
            rsp_tag_d[n]    = infl_tag_q;
            rsp_err_d[n]    = infl_err_q;
         end else if (rsp_valid_q[n] && rsp_ready_s[n]) begin
            rsp_valid_d[n] = 1'b0;
         end else begin
            rsp_valid_d[n] = rsp_valid_q[n];
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q     <= 1'b0;
         infl_valid_q <= 1'b0;
         infl_owner_q <= 1'b0;
         infl_tag_q   <= {TAG_W{1'b0}};
         infl_err_q   <= 1'b0;
         rsp_valid_q  <= 2'b00;
         rsp_result_q <= 64'h0;
         rsp_slt_q    <= 64'h0;
         rsp_tag_q    <= {(2*TAG_W){1'b0}};
         rsp_err_q    <= 2'b00;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         infl_valid_q <= infl_valid_d;
         infl_owner_q <= infl_owner_d;
         infl_tag_q   <= infl_tag_d;
         infl_err_q   <= infl_err_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_slt_q    <= rsp_slt_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign rsp0_valid_o  = rsp_valid_q[0];
   assign rsp0_result_o = rsp_result_q[0];
   assign rsp0_slt_o    = rsp_slt_q[0];
   assign rsp0_tag_o    = rsp_tag_q[0];
   assign rsp0_err_o    = rsp_err_q[0];
   assign rsp1_valid_o  = rsp_valid_q[1];
   assign rsp1_result_o = rsp_result_q[1];
   assign rsp1_slt_o    = rsp_slt_q[1];
   assign rsp1_tag_o    = rsp_tag_q[1];
   assign rsp1_err_o    = rsp_err_q[1];

endmodule
